mod12_run_ctrl: RTL

Run controller for the mod-12 counter datapath (`mod12_counter`: clk, reset, enable, count[3:0]). It accepts START/PAUSE/RESUME/ABORT commands over a valid/ready handshake and clears the counter. It then issues a programmed number of prescaled enable pulses and reports completion. It also counts wraps and monitors the counter's output against an internal shadow model, so it acts both as sequencer and as a self-checking monitor.

---
 rtl/mod12_run_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mod12_run_ctrl.sv
// Run controller for a mod-MOD counter: sequences clear / prescaled enable pulses
// from a command stream and shadows the counter output to flag mismatches.
module mod12_run_ctrl #(
    parameter int MOD    = 12,
    parameter int CYC_W  = 16,
    parameter int PS_W   = 8,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CYC_W-1:0]  cmd_cycles,
    input  logic [PS_W-1:0]   cmd_prescale,
    output logic              cnt_clear,
    output logic              cnt_enable,
    input  logic [3:0]        cnt_count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WRAP_W-1:0] wraps,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_START  = 2'd0;
    localparam logic [1:0] OP_PAUSE  = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_ABORT  = 2'd3;

    localparam logic [3:0] LAST = 4'(MOD - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CYC_W-1:0] rem;
    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  pc;
    logic [3:0]       expected;

    logic accept;
    logic start_ok;
    logic abort_ok;
    logic illegal;
    logic shadow_bad;
    logic last_pulse;

    assign cmd_ready  = (state != S_CLEAR);
    assign accept     = cmd_valid && cmd_ready;
    assign cnt_clear  = (state == S_CLEAR);
    assign cnt_enable = (state == S_RUN) && (pc == ps);
    assign busy       = (state == S_CLEAR) || (state == S_RUN) || (state == S_PAUSE);
    assign done       = (state == S_DONE);
    assign last_pulse = cnt_enable && (rem == CYC_W'(1));

    assign start_ok   = accept && (cmd_op == OP_START) &&
                        ((state == S_IDLE) || (state == S_DONE));
    assign abort_ok   = accept && (cmd_op == OP_ABORT) &&
                        ((state == S_RUN) || (state == S_PAUSE));
    assign shadow_bad = ((state == S_RUN) || (state == S_PAUSE) || (state == S_DONE)) &&
                        (cnt_count != expected);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        illegal   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (cmd_op == OP_START)
                        state_nxt = (cmd_cycles == '0) ? S_DONE : S_CLEAR;
                    else
                        illegal = 1'b1;
                end
            end
            S_CLEAR: state_nxt = S_RUN;
            S_RUN: begin
                if (last_pulse)
                    state_nxt = S_DONE;
                if (accept) begin
                    case (cmd_op)
                        OP_PAUSE: if (!last_pulse) state_nxt = S_PAUSE;
                        OP_ABORT: state_nxt = S_IDLE;
                        default:  illegal = 1'b1;
                    endcase
                end
            end
            S_PAUSE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RESUME: state_nxt = S_RUN;
                        OP_ABORT:  state_nxt = S_IDLE;
                        default:   illegal = 1'b1;
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rem      <= '0;
            ps       <= '0;
            pc       <= '0;
            expected <= '0;
            wraps    <= '0;
            err      <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (illegal || shadow_bad)
                err <= 1'b1;
            if (abort_ok)
                aborted <= 1'b1;
            if (state == S_RUN) begin
                if (cnt_enable) begin
                    pc       <= '0;
                    rem      <= rem - 1'b1;
                    expected <= (expected == LAST) ? 4'd0 : expected + 4'd1;
                    if (expected == LAST && wraps != '1)
                        wraps <= wraps + 1'b1;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
            // A zero-length START only clears flags; the counter and its shadow stay put.
            if (start_ok) begin
                wraps   <= '0;
                err     <= 1'b0;
                aborted <= 1'b0;
                if (cmd_cycles != '0) begin
                    rem      <= cmd_cycles;
                    ps       <= cmd_prescale;
                    pc       <= '0;
                    expected <= '0;
                end
            end
        end
    end

endmodule
